// File: rtl/scaler_vphase_gen.sv
// Vertical phase generator: steps a fixed-point source position per output line and emits
// the two source lines plus blend weight. Define SCALER_VPHASE_CENTER_EN for center-aligned sampling.
module scaler_vphase_gen #(
    parameter int unsigned FRAC_W   = 17,
    parameter int unsigned WEIGHT_W = 8
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RST,
    input  logic                frame_start_i,
    input  logic                line_req_i,
    input  logic [8:0]          vpos_1st_rdline_i,
    input  logic [8:0]          vlines_in_needed_i,
    input  logic [10:0]         vlines_out_i,
    input  logic [FRAC_W:0]     v_interp_factor_i,
    output logic                req_rdy_o,
    output logic                line_vld_o,
    output logic [8:0]          src_line_a_o,
    output logic [8:0]          src_line_b_o,
    output logic [WEIGHT_W-1:0] weight_o,
    output logic [10:0]         out_line_o,
    output logic                last_line_o,
    output logic                frame_done_o
);

    localparam int unsigned IntW  = 11;
    localparam int unsigned AccW  = IntW + FRAC_W;
    localparam int unsigned StepW = 9 + FRAC_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e state_q, state_d;

    // Shadow config, frozen between frame starts
    logic [8:0]        vpos_q;
    logic [8:0]        need_q;
    logic [10:0]       vout_q;
    logic [FRAC_W:0]   factor_q;

    logic [StepW-1:0]  step_q;
    logic [AccW-1:0]   acc_q;
    logic [10:0]       cnt_q;

    logic              s1_vld_q;
    logic [IntW-1:0]   s1_int_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic [10:0]       s1_line_q;

    logic [StepW-1:0]  step_prod;
    logic [AccW-1:0]   acc_init;
    logic              accept;
    logic              s1_last;
    logic              cfg_empty;
    logic [8:0]        need_m1;
    logic [8:0]        a_rel;
    logic [9:0]        b_inc;
    logic [8:0]        b_rel;
    logic              s2_load;

    assign step_prod = {{(StepW-9){1'b0}}, need_q} * {{(StepW-FRAC_W-1){1'b0}}, factor_q};

`ifdef SCALER_VPHASE_CENTER_EN
    localparam logic [StepW-1:0] OneStep  = StepW'(1) << FRAC_W;
    localparam logic [AccW-1:0]  HalfLine = AccW'(1) << (FRAC_W - 1);
    // Center the first sample on the source footprint when downscaling
    assign acc_init = (step_prod >= OneStep)
                    ? (AccW'(step_prod) >> 1) - HalfLine : '0;
`else
    assign acc_init = '0;
`endif

    assign req_rdy_o    = (state_q == StRun) && !s1_vld_q;
    assign accept       = line_req_i && req_rdy_o && !frame_start_i;
    assign s1_last      = (s1_line_q == vout_q - 11'd1);
    assign cfg_empty    = (vout_q == 11'd0) || (need_q == 9'd0);
    assign frame_done_o = (state_q == StDone);
    assign s2_load      = s1_vld_q && !frame_start_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StIdle;
            StLoad:  state_d = cfg_empty ? StDone : StRun;
            StRun:   if (s1_vld_q && s1_last) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (frame_start_i) state_d = StLoad;
    end

    // Stage 2: clamp both taps to the last needed line, then offset to absolute index
    always_comb begin
        need_m1 = need_q - 9'd1;
        a_rel   = (s1_int_q > {2'b00, need_m1}) ? need_m1 : s1_int_q[8:0];
        b_inc   = {1'b0, a_rel} + 10'd1;
        b_rel   = (b_inc > {1'b0, need_m1}) ? need_m1 : b_inc[8:0];
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q      <= StIdle;
            vpos_q       <= '0;
            need_q       <= '0;
            vout_q       <= '0;
            factor_q     <= '0;
            step_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            s1_vld_q     <= 1'b0;
            s1_int_q     <= '0;
            s1_frac_q    <= '0;
            s1_line_q    <= '0;
            line_vld_o   <= 1'b0;
            src_line_a_o <= '0;
            src_line_b_o <= '0;
            weight_o     <= '0;
            out_line_o   <= '0;
            last_line_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (frame_start_i) begin
                vpos_q   <= vpos_1st_rdline_i;
                need_q   <= vlines_in_needed_i;
                vout_q   <= vlines_out_i;
                factor_q <= v_interp_factor_i;
            end

            if (state_q == StLoad) begin
                step_q <= step_prod;
                acc_q  <= acc_init;
                cnt_q  <= '0;
            end else if (accept) begin
                acc_q <= acc_q + AccW'(step_q);
                cnt_q <= cnt_q + 11'd1;
            end

            s1_vld_q <= accept;
            if (accept) begin
                s1_int_q  <= acc_q[AccW-1:FRAC_W];
                s1_frac_q <= acc_q[FRAC_W-1:0];
                s1_line_q <= cnt_q;
            end

            line_vld_o <= s2_load;
            if (s2_load) begin
                src_line_a_o <= vpos_q + a_rel;
                src_line_b_o <= vpos_q + b_rel;
                weight_o     <= (b_rel == a_rel) ? '0 : s1_frac_q[FRAC_W-1 -: WEIGHT_W];
                out_line_o   <= s1_line_q;
                last_line_o  <= s1_last;
            end
        end
    end

endmodule
